// File: rtl/jk_pkg.sv
// -----------------------------------------------------------------------------
// jk_pkg
//
// Shared definitions for JK flip-flop drivers and models:
//   - JK_HOLD / JK_RST / JK_SET / JK_TOG : two-bit {j,k} command encodings
//   - jk_state_e                          : burst sequencer states
//   - jk_next()                           : JK characteristic (next q from q,j,k)
// -----------------------------------------------------------------------------
package jk_pkg;

    // {j,k} command encodings
    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_RST  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TOG  = 2'b11;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } jk_state_e;

    // JK characteristic equation: q+ = j&~q | ~k&q
    function automatic logic jk_next(input logic q, input logic j, input logic k);
        logic q_n;
        unique case ({j, k})
            JK_HOLD: q_n = q;
            JK_RST:  q_n = 1'b0;
            JK_SET:  q_n = 1'b1;
            JK_TOG:  q_n = ~q;
            default: q_n = q;
        endcase
        return q_n;
    endfunction

endpackage

// File: rtl/jk_excite.sv
// -----------------------------------------------------------------------------
// jk_excite
//
// Purely combinational JK excitation encoder: picks the {j,k} command that
// moves a JK flop from its predicted state to the requested target state.
//
// Ports:
//   q_pred_i  - state the flop will hold when this command takes effect
//   target_i  - desired state after the command
//   toggle_i  - 1: use toggle (11) for changes, 0: use explicit set/reset
//   jk_o      - {j,k} command
// -----------------------------------------------------------------------------
module jk_excite
    import jk_pkg::*;
(
    input  logic       q_pred_i,
    input  logic       target_i,
    input  logic       toggle_i,
    output logic [1:0] jk_o
);

    always_comb begin
        jk_o = JK_HOLD;
        if (target_i != q_pred_i) begin
            if (toggle_i) begin
                jk_o = JK_TOG;
            end else if (target_i) begin
                jk_o = JK_SET;
            end else begin
                jk_o = JK_RST;
            end
        end
    end

endmodule

// File: rtl/jk_seq_driver.sv
// -----------------------------------------------------------------------------
// jk_seq_driver
//
// Accepts WIDTH-bit target patterns over a valid/ready handshake and plays
// them out LSB first as one registered {j,k} command per cycle for an external
// JK flop. An internal JK model tracks the flop state so each command is the
// excitation from the predicted state to the next target bit; the flop's q is
// fed back and any divergence from the model sets a sticky flag.
//
// Ports:
//   clk          - clock, all state on rising edge
//   rst_n        - asynchronous active-low reset
//   in_valid_i   - pattern word offered
//   in_ready_o   - high only while idle (combinational)
//   in_data_i    - target pattern, bit 0 driven first
//   in_toggle_i  - encoding policy for the word (1: toggle, 0: set/reset)
//   abort_i      - synchronous burst cancel
//   q_fb_i       - q from the external flop
//   j_o, k_o     - registered JK commands
//   q_model_o    - modelled flop state
//   busy_o       - high while shifting a word out
//   done_o       - one-cycle pulse after the last command of a burst
//   mismatch_o   - sticky q_fb_i / q_model_o divergence flag
// -----------------------------------------------------------------------------
module jk_seq_driver
    import jk_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             in_toggle_i,
    input  logic             abort_i,
    input  logic             q_fb_i,
    output logic             j_o,
    output logic             k_o,
    output logic             q_model_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             mismatch_o
);

    localparam int unsigned    CntW    = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    jk_state_e         state_q, state_d;
    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              toggle_q, toggle_d;
    logic [1:0]        jk_q, jk_d;
    logic              done_q, done_d;
    logic              q_model_q;
    logic              mismatch_q;

    logic              accept;
    logic              last_bit;
    logic              q_pred;
    logic [1:0]        jk_exc;

    // The command on j/k now is applied by the flop at the next edge, so the
    // command registered at that edge must be encoded against the post-edge
    // state, not the current one.
    assign q_pred   = jk_next(q_model_q, jk_q[1], jk_q[0]);
    assign accept   = in_valid_i & in_ready_o;
    assign last_bit = (cnt_q == CntLast);

    jk_excite u_jk_excite (
        .q_pred_i (q_pred),
        .target_i (shreg_q[0]),
        .toggle_i (toggle_q),
        .jk_o     (jk_exc)
    );

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // abort and the final bit share the same exit
                if (abort_i || last_bit) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Outputs and datapath next values
    // ---------------------------------------------------------------------
    always_comb begin
        in_ready_o = (state_q == IDLE);
        busy_o     = (state_q == SHIFT);

        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        toggle_d = toggle_q;
        jk_d     = JK_HOLD;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    shreg_d  = in_data_i;
                    toggle_d = in_toggle_i;
                    cnt_d    = '0;
                end
            end
            SHIFT: begin
                if (!abort_i) begin
                    jk_d    = jk_exc;
                    shreg_d = shreg_q >> 1;
                    cnt_d   = cnt_q + CntW'(1);
                    done_d  = last_bit;
                end
            end
            default: begin
                jk_d = JK_HOLD;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Datapath, command, model and feedback registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q    <= '0;
            cnt_q      <= '0;
            toggle_q   <= 1'b0;
            jk_q       <= JK_HOLD;
            done_q     <= 1'b0;
            q_model_q  <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            toggle_q   <= toggle_d;
            jk_q       <= jk_d;
            done_q     <= done_d;
            // model keeps applying whatever is on j/k, including after abort
            q_model_q  <= q_pred;
            mismatch_q <= mismatch_q | (q_fb_i != q_model_q);
        end
    end

    assign j_o        = jk_q[1];
    assign k_o        = jk_q[0];
    assign q_model_o  = q_model_q;
    assign done_o     = done_q;
    assign mismatch_o = mismatch_q;

endmodule
